// File: rtl/sensor_spi_reader_if.sv
// Pin-level bundle of the sensor reader: trigger, shared ncs/scl, per-channel sda,
// and the extracted data with its valid strobe and busy flag.
interface sensor_spi_reader_if #(
    parameter int N_CH   = 1,
    parameter int DATA_W = 8
);
    logic                   start;
    logic                   ncs;
    logic                   scl;
    logic [N_CH-1:0]        sda;
    logic [N_CH*DATA_W-1:0] data;
    logic                   valid;
    logic                   busy;

    modport master (input start, sda, output ncs, scl, data, valid, busy);
    modport slave  (output start, sda, input ncs, scl, data, valid, busy);
endinterface

// File: rtl/sensor_spi_reader.sv
// SPI-style reader: drives ncs/scl for N_CH sensors, shifts a frame in from each sda
// in parallel and publishes a DATA_W field per channel with a one-cycle valid strobe.
module sensor_spi_reader #(
    parameter int CLK_DIV    = 25,
    parameter int FRAME_BITS = 16,
    parameter int LEAD_BITS  = 3,
    parameter int DATA_W     = 8,
    parameter int N_CH       = 1,
    parameter int QUIET_BITS = 3,
    parameter bit CONTINUOUS = 1'b1
) (
    input logic                 clk,
    input logic                 rst,
    sensor_spi_reader_if.master bus
);
    localparam int DIV_W       = $clog2(CLK_DIV);
    localparam int BIT_W       = $clog2(FRAME_BITS + 1);
    localparam int QUIET_TICKS = 2 * QUIET_BITS;
    localparam int QUIET_W     = $clog2(QUIET_TICKS + 1);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, QUIET} state_t;
    state_t state, state_next;

    logic [DIV_W-1:0]                div_cnt;
    logic [BIT_W-1:0]                bit_cnt;
    logic [QUIET_W-1:0]              quiet_cnt;
    logic                            scl_q, ncs_q, busy_q, valid_q;
    logic [N_CH-1:0][FRAME_BITS-1:0] sr, sr_next;
    logic [N_CH*DATA_W-1:0]          data_q, data_next;
    logic                            tick, rise_tick, last_rise;

    assign tick      = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign rise_tick = (state == SHIFT) && tick && !scl_q;
    assign last_rise = rise_tick && (bit_cnt == BIT_W'(FRAME_BITS - 1));

    // Data is taken from the shift value including the final bit, so it lands one clk after that tick.
    always_comb begin
        sr_next   = sr;
        data_next = data_q;
        for (int c = 0; c < N_CH; c++) begin
            sr_next[c] = {sr[c][FRAME_BITS-2:0], bus.sda[c]};
            data_next[c*DATA_W +: DATA_W] = sr_next[c][FRAME_BITS-1-LEAD_BITS -: DATA_W];
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (CONTINUOUS || bus.start) state_next = SETUP;
            SETUP:   if (tick) state_next = SHIFT;
            SHIFT:   if (last_rise) state_next = QUIET;
            QUIET:   if (tick && quiet_cnt == QUIET_W'(QUIET_TICKS - 1))
                         state_next = CONTINUOUS ? SETUP : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ncs/busy are registered from the next state so they switch exactly on state entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            quiet_cnt <= '0;
            scl_q     <= 1'b1;
            ncs_q     <= 1'b1;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            sr        <= '0;
            data_q    <= '0;
        end else begin
            state   <= state_next;
            valid_q <= last_rise;
            ncs_q   <= !(state_next == SETUP || state_next == SHIFT);
            busy_q  <= (state_next != IDLE);

            if (state_next != state || tick) div_cnt <= '0;
            else                             div_cnt <= div_cnt + 1'b1;

            if (state != SHIFT) scl_q <= 1'b1;
            else if (tick)      scl_q <= !scl_q;

            if (state == SETUP) begin
                bit_cnt <= '0;
            end else if (rise_tick) begin
                bit_cnt <= bit_cnt + 1'b1;
                sr      <= sr_next;
            end

            if (state != QUIET) quiet_cnt <= '0;
            else if (tick)      quiet_cnt <= quiet_cnt + 1'b1;

            if (last_rise) data_q <= data_next;
        end
    end

    assign bus.ncs   = ncs_q;
    assign bus.scl   = scl_q;
    assign bus.data  = data_q;
    assign bus.valid = valid_q;
    assign bus.busy  = busy_q;
endmodule
